// File: rtl/arbiter_moore_ej2.sv
// arbiter_moore_ej2: two-requester Moore arbiter that shares one controller datapath.
// It gives the resource to at most one master at a time, in round-robin order.
// Each grant is limited to MAX_HOLD cycles. One dead (GAP) cycle is inserted between grants.
// Every output is decoded from registered state only.
//
// Ports:
//   inputClk       clock, all state changes on the rising edge
//   inputReset     synchronous active-high reset
//   inputReq0/1    level requests from master 0 / master 1
//   inputDone      current owner finished (only looked at in a grant state)
//   outputGnt0/1   master 0 / master 1 owns the shared controller
//   outputBusy     any grant state or the GAP cycle
//   outputTimeout  high during the GAP cycle that follows a grant ended by the hold limit
module arbiter_moore_ej2 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic inputClk,
  input  logic inputReset,
  input  logic inputReq0,
  input  logic inputReq1,
  input  logic inputDone,
  output logic outputGnt0,
  output logic outputGnt1,
  output logic outputBusy,
  output logic outputTimeout
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StG0   = 2'b01,
    StG1   = 2'b10,
    StGap  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_HOLD - 1);

  state_e           state_q;
  logic             last_gnt_q;  // 0: master 0 owned last, 1: master 1 owned last
  logic [CNT_W-1:0] cnt_q;
  logic             t_flag_q;

  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      t_flag_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          t_flag_q <= 1'b0;
          cnt_q    <= '0;
          if (inputReq0 && inputReq1) begin
            state_q <= last_gnt_q ? StG0 : StG1;
          end else if (inputReq0) begin
            state_q <= StG0;
          end else if (inputReq1) begin
            state_q <= StG1;
          end
        end
        StG0: begin
          if (inputDone || !inputReq0 || (cnt_q == LastCnt)) begin
            state_q    <= StGap;
            last_gnt_q <= 1'b0;
            // Only a pure hold-limit release raises the timeout flag.
            t_flag_q   <= !inputDone && inputReq0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StG1: begin
          if (inputDone || !inputReq1 || (cnt_q == LastCnt)) begin
            state_q    <= StGap;
            last_gnt_q <= 1'b1;
            t_flag_q   <= !inputDone && inputReq1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StGap: begin
          state_q  <= StIdle;
          t_flag_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign outputGnt0    = (state_q == StG0);
  assign outputGnt1    = (state_q == StG1);
  assign outputBusy    = (state_q != StIdle);
  assign outputTimeout = t_flag_q;

endmodule

// File: tb/tb_arbiter_moore_ej2.sv
// Directed testbench for arbiter_moore_ej2 with MAX_HOLD=8.
// Outputs are packed as {gnt0, gnt1, busy, timeout} and checked 1 time unit after each rising edge.
module tb_arbiter_moore_ej2;

  logic clk = 1'b0;
  logic rst, req0, req1, done;
  logic gnt0, gnt1, busy, timeout;

  int n_vec = 0;
  int n_err = 0;

  arbiter_moore_ej2 #(
    .MAX_HOLD(8),
    .CNT_W   (4)
  ) dut (
    .inputClk     (clk),
    .inputReset   (rst),
    .inputReq0    (req0),
    .inputReq1    (req1),
    .inputDone    (done),
    .outputGnt0   (gnt0),
    .outputGnt1   (gnt1),
    .outputBusy   (busy),
    .outputTimeout(timeout)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] EIdle = 4'b0000;
  localparam logic [3:0] EG0   = 4'b1010;
  localparam logic [3:0] EG1   = 4'b0110;
  localparam logic [3:0] EGap  = 4'b0010;
  localparam logic [3:0] EGapT = 4'b0011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {gnt0, gnt1, busy, timeout};
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Invariants that must hold on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (n_vec > 0) begin
      n_vec++;
      assert (!(gnt0 && gnt1) && (!(gnt0 || gnt1) || busy))
      else begin
        n_err++;
        $error("FAIL invariant: observed gnt0=%b gnt1=%b busy=%b expected exclusive grant with busy",
               gnt0, gnt1, busy);
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    tick(); chk("reset_1", EIdle);
    req0 = 1'b1;  // reset must win over the request
    tick(); chk("reset_held", EIdle);

    // Test 1: master 0 alone, Done asserted in grant cycle 3
    rst = 1'b0;
    tick(); chk("t1_g0_c1", EG0);
    tick(); chk("t1_g0_c2", EG0);
    tick(); chk("t1_g0_c3", EG0);
    done = 1'b1;
    tick(); chk("t1_gap", EGap);
    done = 1'b0; req0 = 1'b0;
    tick(); chk("t1_idle", EIdle);

    // Test 2: both masters request after reset, so grants go G0, G1, G0, G1
    rst = 1'b1;
    tick(); chk("t2_reset", EIdle);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("t2_grant%0d_c1", i), (i % 2 == 0) ? EG0 : EG1);
      tick(); chk($sformatf("t2_grant%0d_c2", i), (i % 2 == 0) ? EG0 : EG1);
      done = 1'b1;
      tick(); chk($sformatf("t2_gap%0d", i), EGap);
      done = 1'b0;
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick(); chk($sformatf("t2_idle%0d", i), EIdle);
    end

    // Test 3: master 1 holds until the limit, giving 8 cycles and one Timeout cycle
    req1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(); chk($sformatf("t3_g1_c%0d", i), EG1);
    end
    tick(); chk("t3_gap_timeout", EGapT);
    tick(); chk("t3_idle", EIdle);
    tick(); chk("t3_regrant_g1", EG1);

    // Test 4: Done asserted in the final (8th) cycle is a normal release
    for (int i = 2; i <= 8; i++) begin
      tick(); chk($sformatf("t4_g1_c%0d", i), EG1);
    end
    done = 1'b1;
    tick(); chk("t4_gap_no_timeout", EGap);
    done = 1'b0; req1 = 1'b0;
    tick(); chk("t4_idle", EIdle);

    // Test 5: Req0 dropped in grant cycle 2; afterwards lastGnt=0, so a tie goes to G1
    req0 = 1'b1;
    tick(); chk("t5_g0_c1", EG0);
    tick(); chk("t5_g0_c2", EG0);
    req0 = 1'b0;
    tick(); chk("t5_gap", EGap);
    req0 = 1'b1; req1 = 1'b1;
    tick(); chk("t5_idle", EIdle);
    tick(); chk("t5_tie_g1", EG1);
    done = 1'b1;
    tick(); chk("t5_gap2", EGap);
    done = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); chk("t5_idle2", EIdle);

    // Test 6: reset during G0 cycle 4 drops the grant with no GAP cycle
    req0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk($sformatf("t6_g0_c%0d", i), EG0);
    end
    rst = 1'b1; req1 = 1'b1;
    tick(); chk("t6_reset_drop", EIdle);
    rst = 1'b0;
    tick(); chk("t6_tie_g0", EG0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
